// File: rtl/spi_slave.sv
// spi_slave: SPI target shift engine (SCLK idles high, MISO on fall, MOSI on rise, CS active-low).
module spi_slave #(
  parameter int WORDBITS    = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clock,
  input  logic                resetN,
  input  logic                inSCLK,
  input  logic                inCS,
  input  logic                inMOSI,
  output logic                outMISO,
  output logic                outMISOEnable,
  input  logic [WORDBITS-1:0] txData,
  input  logic                txLoad,
  output logic                txEmpty,
  output logic [WORDBITS-1:0] rxData,
  output logic                rxValid,
  output logic                frameError,
  output logic                busy
);
  localparam int CW = $clog2(WORDBITS);
  localparam logic [CW-1:0] LAST = CW'(WORDBITS - 1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state;
  logic [SYNC_STAGES-1:0] sclk_q, cs_q, mosi_q, fill;
  logic sclk_prev, cs_prev, armed, skip_fall;
  logic [WORDBITS-1:0] hold, tx_shift, rx_shift, word;
  logic [CW-1:0] bit_count;
  logic sclk_s, cs_s, mosi_s, sclk_rise, sclk_fall, cs_rise, cs_fall, start, word_done, consume;
  assign sclk_s    = sclk_q[SYNC_STAGES-1];
  assign cs_s      = cs_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;
  assign cs_rise   = cs_s & ~cs_prev;
  assign cs_fall   = ~cs_s & cs_prev;
  assign start     = (state == IDLE) && cs_fall && armed;
  assign word_done = (state == SHIFT) && !cs_rise && sclk_rise && (bit_count == '0);
  assign consume   = start | word_done;
  assign word      = txEmpty ? '0 : hold;
  // armed only once CS has been seen high through a fully flushed synchroniser,
  // so a frame already in progress at reset release is ignored
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      sclk_q    <= '1;
      cs_q      <= '1;
      mosi_q    <= '0;
      fill      <= '0;
      sclk_prev <= 1'b1;
      cs_prev   <= 1'b1;
      armed     <= 1'b0;
    end else begin
      sclk_q    <= {sclk_q[SYNC_STAGES-2:0], inSCLK};
      cs_q      <= {cs_q[SYNC_STAGES-2:0], inCS};
      mosi_q    <= {mosi_q[SYNC_STAGES-2:0], inMOSI};
      fill      <= {fill[SYNC_STAGES-2:0], 1'b1};
      sclk_prev <= sclk_s;
      cs_prev   <= cs_s;
      armed     <= armed | (fill[SYNC_STAGES-1] & cs_s);
    end
  end
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      hold    <= '0;
      txEmpty <= 1'b1;
    end else if (txLoad) begin
      hold    <= txData;
      txEmpty <= 1'b0;
    end else if (consume) begin
      txEmpty <= 1'b1;
    end
  end
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state         <= IDLE;
      outMISO       <= 1'b0;
      outMISOEnable <= 1'b0;
      rxData        <= '0;
      rxValid       <= 1'b0;
      frameError    <= 1'b0;
      busy          <= 1'b0;
      tx_shift      <= '0;
      rx_shift      <= '0;
      bit_count     <= '0;
      skip_fall     <= 1'b0;
    end else begin
      rxValid    <= 1'b0;
      frameError <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          outMISO       <= word[WORDBITS-1];
          tx_shift      <= word << 1;
          bit_count     <= LAST;
          skip_fall     <= 1'b1;
          outMISOEnable <= 1'b1;
          busy          <= 1'b1;
          state         <= SHIFT;
        end
      end else if (cs_rise) begin
        frameError    <= bit_count != LAST;
        outMISOEnable <= 1'b0;
        outMISO       <= 1'b0;
        busy          <= 1'b0;
        state         <= IDLE;
      end else if (sclk_fall) begin
        if (skip_fall) begin
          skip_fall <= 1'b0;
        end else begin
          outMISO  <= tx_shift[WORDBITS-1];
          tx_shift <= tx_shift << 1;
        end
      end else if (sclk_rise) begin
        rx_shift <= {rx_shift[WORDBITS-2:0], mosi_s};
        if (word_done) begin
          rxData    <= {rx_shift[WORDBITS-2:0], mosi_s};
          rxValid   <= 1'b1;
          bit_count <= LAST;
          tx_shift  <= word;
        end else begin
          bit_count <= bit_count - 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: randomized SPI master driving spi_slave, checked against a holding-register/word model.
module tb_spi_slave;
  localparam int W  = 8;
  localparam int SS = 2;
  logic clock = 0, resetN = 0, inSCLK = 1, inCS = 1, inMOSI = 0, txLoad = 0;
  logic [W-1:0] txData = '0;
  logic outMISO, outMISOEnable, txEmpty, rxValid, frameError, busy;
  logic [W-1:0] rxData;
  int n_chk = 0, n_fail = 0, rxv_cnt = 0, fe_cnt = 0;
  logic [7:0] rx_q[$];
  logic [7:0] m_hold = '0;
  bit m_empty = 1;

  spi_slave #(.WORDBITS(W), .SYNC_STAGES(SS)) dut (
    .clock(clock), .resetN(resetN), .inSCLK(inSCLK), .inCS(inCS), .inMOSI(inMOSI),
    .outMISO(outMISO), .outMISOEnable(outMISOEnable), .txData(txData), .txLoad(txLoad),
    .txEmpty(txEmpty), .rxData(rxData), .rxValid(rxValid), .frameError(frameError), .busy(busy)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (resetN) begin
      if (rxValid) begin
        rxv_cnt++;
        rx_q.push_back(rxData);
      end
      if (frameError) fe_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic m_consume(output logic [7:0] w);
    w = m_empty ? 8'h00 : m_hold;
    m_empty = 1;
  endtask

  task automatic load(input logic [7:0] v);
    txData = v;
    txLoad = 1;
    cyc(1);
    txLoad = 0;
    m_hold = v;
    m_empty = 0;
  endtask

  // n words; abort>0 cuts the last word after that many rises; rl: <0 none, >255 random, else fixed reload
  task automatic frame(input int n, input int abort, input int rl, input bit collide,
                       input logic [7:0] cv, input int mosi0);
    logic [7:0] exp_tx, got, sent, prev_rx;
    logic [7:0] sent_q[$];
    int nb;
    rx_q.delete();
    rxv_cnt = 0;
    fe_cnt = 0;
    prev_rx = rxData;
    inCS = 0;
    if (collide) begin
      cyc(SS);
      txData = cv;
      txLoad = 1;
      cyc(1);
      txLoad = 0;
      m_consume(exp_tx);
      m_hold = cv;
      m_empty = 0;
      cyc(6);
    end else begin
      m_consume(exp_tx);
      cyc(8);
    end
    chk("txempty_csfall", {31'd0, txEmpty}, {31'd0, m_empty});
    chk("miso_en_frame", {31'd0, outMISOEnable}, 1);
    chk("busy_frame", {31'd0, busy}, 1);
    for (int w = 0; w < n; w++) begin
      sent = (w == 0 && mosi0 >= 0) ? mosi0[7:0] : 8'($urandom);
      got = '0;
      nb = (abort > 0 && w == n - 1) ? abort : 8;
      for (int b = 0; b < nb; b++) begin
        inSCLK = 0;
        inMOSI = sent[7-b];
        if (rl >= 0 && w < n - 1 && b == nb - 1) load(rl > 255 ? 8'($urandom) : rl[7:0]);
        cyc(8);
        got = {got[6:0], outMISO};
        inSCLK = 1;
        cyc(8);
      end
      if (nb == 8) begin
        chk("miso_word", {24'd0, got}, {24'd0, exp_tx});
        sent_q.push_back(sent);
        m_consume(exp_tx);
      end else begin
        chk("miso_partial", {24'd0, got}, {24'd0, exp_tx >> (8 - nb)});
      end
    end
    cyc(4);
    inCS = 1;
    cyc(10);
    chk("rx_count", rxv_cnt, sent_q.size());
    foreach (sent_q[i]) if (i < rx_q.size()) chk("rx_data", {24'd0, rx_q[i]}, {24'd0, sent_q[i]});
    chk("frame_err", fe_cnt, (abort > 0) ? 1 : 0);
    if (abort > 0) chk("rx_held", {24'd0, rxData}, {24'd0, prev_rx});
    chk("miso_en_idle", {31'd0, outMISOEnable}, 0);
    chk("busy_idle", {31'd0, busy}, 0);
    chk("txempty_end", {31'd0, txEmpty}, {31'd0, m_empty});
  endtask

  initial begin
    cyc(3);
    chk("rst_miso", {31'd0, outMISO}, 0);
    chk("rst_en", {31'd0, outMISOEnable}, 0);
    chk("rst_txempty", {31'd0, txEmpty}, 1);
    chk("rst_rxdata", {24'd0, rxData}, 0);
    chk("rst_rxvalid", {31'd0, rxValid}, 0);
    chk("rst_ferr", {31'd0, frameError}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    resetN = 1;
    cyc(6);
    load(8'hA5);
    frame(1, 0, -1, 0, 8'h00, 'h3C);
    frame(1, 0, -1, 0, 8'h00, 'hFF);
    load(8'h12);
    frame(2, 0, 'h34, 0, 8'h00, -1);
    load(8'($urandom));
    frame(1, 5, -1, 0, 8'h00, -1);
    load(8'h11);
    frame(1, 7, -1, 1, 8'h77, -1);
    frame(1, 0, -1, 0, 8'h00, -1);
    load(8'h5A);
    rxv_cnt = 0;
    inCS = 0;
    cyc(8);
    for (int b = 0; b < 8; b++) begin
      if (b == 3) begin
        resetN = 0;
        cyc(2);
        chk("rst_mid_busy", {31'd0, busy}, 0);
        chk("rst_mid_en", {31'd0, outMISOEnable}, 0);
        resetN = 1;
        m_empty = 1;
        m_hold = '0;
      end
      inSCLK = 0;
      inMOSI = 1'($urandom);
      cyc(8);
      inSCLK = 1;
      cyc(8);
      if (b > 3) chk("rst_after_busy", {31'd0, busy}, 0);
    end
    inCS = 1;
    cyc(10);
    chk("rst_after_rxv", rxv_cnt, 0);
    chk("rst_after_rxdata", {24'd0, rxData}, 0);
    chk("rst_after_txempty", {31'd0, txEmpty}, 1);
    load(8'($urandom));
    frame(1, 0, -1, 0, 8'h00, -1);
    for (int k = 0; k < 10; k++) begin
      if ($urandom % 2 == 1) load(8'($urandom));
      frame(int'($urandom_range(1, 3)), 0, ($urandom % 2 == 1) ? 256 : -1, 0, 8'h00, -1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
